// File: rtl/mul_pkg.sv
// Shared opcode encoding and helpers for the LA32R multiply pipeline.
package mul_pkg;

  localparam int unsigned MUL_OP_WIDTH = 2;
  localparam int unsigned MUL_CORE_W   = 34;
  localparam int unsigned MUL_PROD_W   = 64;

  typedef enum logic [MUL_OP_WIDTH-1:0] {
    MUL_OP_W     = 2'b00,
    MUL_OP_MULH  = 2'b01,
    MUL_OP_MULHU = 2'b10,
    MUL_OP_RSVD  = 2'b11
  } mul_op_e;

  function automatic logic mul_op_signed(input mul_op_e op);
    return op == MUL_OP_MULH;
  endfunction

  function automatic logic mul_op_high(input mul_op_e op);
    return (op == MUL_OP_MULH) || (op == MUL_OP_MULHU);
  endfunction

endpackage

// File: rtl/mul_pipe_if.sv
// Issue/result handshake bundle for mul_pipe, plus the pipeline flush request.
interface mul_pipe_if
  import mul_pkg::*;
#(
  parameter int unsigned TAG_W = 5
);

  logic                    in_valid;
  logic                    in_ready;
  logic [MUL_OP_WIDTH-1:0] in_op;
  logic [31:0]             in_x;
  logic [31:0]             in_y;
  logic [TAG_W-1:0]        in_tag;
  logic                    flush;
  logic                    out_valid;
  logic                    out_ready;
  logic [31:0]             out_result;
  logic [TAG_W-1:0]        out_tag;

  modport master (
    output in_valid, in_op, in_x, in_y, in_tag, flush, out_ready,
    input  in_ready, out_valid, out_result, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_x, in_y, in_tag, flush, out_ready,
    output in_ready, out_valid, out_result, out_tag
  );

endinterface

// File: rtl/mul_34.sv
// Combinational 34-bit radix-4 Booth multiplier core; 32-bit operands are
// extended to 34 bits so one datapath covers signed and unsigned products.
module mul_34
  import mul_pkg::*;
(
  input  logic                  mul_signed,
  input  logic [31:0]           x,
  input  logic [31:0]           y,
  output logic [MUL_PROD_W-1:0] result
);

  localparam int unsigned PP_N = MUL_CORE_W / 2;

  logic [MUL_CORE_W-1:0] x_ext;
  logic [MUL_CORE_W-1:0] y_ext;
  logic [MUL_CORE_W:0]   y_booth;
  logic [MUL_PROD_W-1:0] x_wide;
  logic [MUL_PROD_W-1:0] pp;
  logic [MUL_PROD_W-1:0] acc;
  logic [2:0]            trip;

  // Only the low 64 bits of the 68-bit product are ever needed, so the
  // partial-product sum is carried modulo 2^64.
  always_comb begin
    x_ext   = {{2{mul_signed & x[31]}}, x};
    y_ext   = {{2{mul_signed & y[31]}}, y};
    y_booth = {y_ext, 1'b0};
    x_wide  = {{(MUL_PROD_W - MUL_CORE_W){x_ext[MUL_CORE_W-1]}}, x_ext};
    acc     = '0;
    pp      = '0;
    trip    = '0;
    for (int unsigned i = 0; i < PP_N; i++) begin
      trip = y_booth[2*i +: 3];
      unique case (trip)
        3'b001, 3'b010: pp = x_wide;
        3'b011:         pp = x_wide << 1;
        3'b100:         pp = -(x_wide << 1);
        3'b101, 3'b110: pp = -x_wide;
        default:        pp = '0;
      endcase
      acc = acc + (pp << (2*i));
    end
    result = acc;
  end

endmodule

// File: rtl/mul_res_sel.sv
// Picks the architectural 32-bit result out of the 64-bit product by opcode.
module mul_res_sel
  import mul_pkg::*;
(
  input  mul_op_e               op,
  input  logic [MUL_PROD_W-1:0] product,
  output logic [31:0]           result
);

  always_comb begin
    result = product[31:0];
    if (mul_op_high(op)) begin
      result = product[63:32];
    end
  end

endmodule

// File: rtl/mul_pipe.sv
// Two-stage valid/ready EXE wrapper around mul_34 (S1 operands, S2 product).
// Define MUL_PIPE_STAT_EN to build the completed-op and stall counters.
module mul_pipe
  import mul_pkg::*;
#(
  parameter int unsigned TAG_W = 5
) (
  input  logic        mul_clk,
  input  logic        resetn,
  mul_pipe_if.slave   bus,
  output logic [31:0] stat_done,
  output logic [31:0] stat_stall
);

  logic                  s1_valid_q, s1_valid_d;
  logic [31:0]           s1_x_q, s1_x_d;
  logic [31:0]           s1_y_q, s1_y_d;
  mul_op_e               s1_op_q, s1_op_d;
  logic [TAG_W-1:0]      s1_tag_q, s1_tag_d;

  logic                  s2_valid_q, s2_valid_d;
  logic [MUL_PROD_W-1:0] s2_prod_q, s2_prod_d;
  mul_op_e               s2_op_q, s2_op_d;
  logic [TAG_W-1:0]      s2_tag_q, s2_tag_d;

  logic                  s2_free;
  logic                  s1_adv;
  logic                  in_ready;
  logic                  accept;
  logic                  out_valid;
  logic                  out_fire;
  logic                  core_signed;
  logic [MUL_PROD_W-1:0] product;
  logic [31:0]           sel_result;

  mul_34 u_mul_34 (
    .mul_signed (core_signed),
    .x          (s1_x_q),
    .y          (s1_y_q),
    .result     (product)
  );

  mul_res_sel u_res_sel (
    .op      (s2_op_q),
    .product (s2_prod_q),
    .result  (sel_result)
  );

  always_comb begin
    core_signed = mul_op_signed(s1_op_q);
    s2_free     = !s2_valid_q || bus.out_ready;
    s1_adv      = s1_valid_q && s2_free;
    in_ready    = (!s1_valid_q || s2_free) && !bus.flush;
    accept      = bus.in_valid && in_ready;
    out_valid   = s2_valid_q && !bus.flush;
    out_fire    = out_valid && bus.out_ready;
  end

  // Flush kills valids but leaves data registers untouched.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_x_d     = s1_x_q;
    s1_y_d     = s1_y_q;
    s1_op_d    = s1_op_q;
    s1_tag_d   = s1_tag_q;
    if (bus.flush) begin
      s1_valid_d = 1'b0;
    end else if (accept) begin
      s1_valid_d = 1'b1;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
    if (accept) begin
      s1_x_d   = bus.in_x;
      s1_y_d   = bus.in_y;
      s1_op_d  = mul_op_e'(bus.in_op);
      s1_tag_d = bus.in_tag;
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_prod_d  = s2_prod_q;
    s2_op_d    = s2_op_q;
    s2_tag_d   = s2_tag_q;
    if (bus.flush) begin
      s2_valid_d = 1'b0;
    end else if (s1_adv) begin
      s2_valid_d = 1'b1;
      s2_prod_d  = product;
      s2_op_d    = s1_op_q;
      s2_tag_d   = s1_tag_q;
    end else if (out_fire) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge mul_clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_op_q    <= MUL_OP_W;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_prod_q  <= '0;
      s2_op_q    <= MUL_OP_W;
      s2_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_x_q     <= s1_x_d;
      s1_y_q     <= s1_y_d;
      s1_op_q    <= s1_op_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      s2_prod_q  <= s2_prod_d;
      s2_op_q    <= s2_op_d;
      s2_tag_q   <= s2_tag_d;
    end
  end

  always_comb begin
    bus.in_ready   = in_ready;
    bus.out_valid  = out_valid;
    bus.out_result = sel_result;
    bus.out_tag    = s2_tag_q;
  end

`ifdef MUL_PIPE_STAT_EN
  logic [31:0] stat_done_q, stat_done_d;
  logic [31:0] stat_stall_q, stat_stall_d;
  logic        out_stall;

  always_comb begin
    out_stall    = out_valid && !bus.out_ready;
    stat_done_d  = stat_done_q + 32'(out_fire);
    stat_stall_d = stat_stall_q + 32'(out_stall);
  end

  always_ff @(posedge mul_clk or negedge resetn) begin
    if (!resetn) begin
      stat_done_q  <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_done_q  <= stat_done_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  always_comb begin
    stat_done  = stat_done_q;
    stat_stall = stat_stall_q;
  end
`else
  always_comb begin
    stat_done  = '0;
    stat_stall = '0;
  end
`endif

endmodule

// File: tb/tb_mul_pipe.sv
// Self-checking bench for mul_pipe: directed scenarios plus randomized traffic
// scored against an arithmetic reference model with an in-order expectation queue.
module tb_mul_pipe;
  import mul_pkg::*;

  localparam int unsigned TAG_W = 5;

  typedef struct {
    logic [31:0]      res;
    logic [TAG_W-1:0] tag;
  } exp_t;

  typedef struct {
    logic [31:0]      res;
    logic [TAG_W-1:0] tag;
    int unsigned      cyc;
  } obs_t;

  logic        mul_clk = 1'b0;
  logic        resetn  = 1'b0;
  logic [31:0] stat_done;
  logic [31:0] stat_stall;

  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc       = 0;
  int unsigned done_cnt  = 0;
  int unsigned stall_cnt = 0;

  exp_t q[$];
  obs_t obs[$];

  logic             prev_stall = 1'b0;
  logic [31:0]      prev_res   = '0;
  logic [TAG_W-1:0] prev_tag   = '0;

  mul_pipe_if #(.TAG_W(TAG_W)) bus ();

  mul_pipe #(.TAG_W(TAG_W)) dut (
    .mul_clk    (mul_clk),
    .resetn     (resetn),
    .bus        (bus),
    .stat_done  (stat_done),
    .stat_stall (stat_stall)
  );

  always #5 mul_clk = ~mul_clk;

  always @(posedge mul_clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs_v, input logic [63:0] exp_v);
    checks++;
    if (obs_v !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs_v, exp_v);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] x,
                                             input logic [31:0] y);
    logic [63:0]        uprod;
    logic signed [63:0] sprod;
    uprod = {32'h0, x} * {32'h0, y};
    sprod = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
    case (op)
      2'b01:   return sprod[63:32];
      2'b10:   return uprod[63:32];
      default: return uprod[31:0];
    endcase
  endfunction

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Scoreboard: sampled mid-cycle, predicting the handshakes of the coming edge.
  always @(negedge mul_clk) begin : monitor
    exp_t e;
    if (!resetn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !bus.flush) begin
        check_eq("hold_valid", 64'(bus.out_valid), 64'd1);
        check_eq("hold_result", 64'(bus.out_result), 64'(prev_res));
        check_eq("hold_tag", 64'(bus.out_tag), 64'(prev_tag));
      end
      if (bus.flush) begin
        check_eq("flush_out_valid", 64'(bus.out_valid), 64'd0);
        q.delete();
      end else begin
        if (bus.out_valid && bus.out_ready) begin
          if (q.size() != 0) begin
            e = q.pop_front();
          end else begin
            e.res = 'x;
            e.tag = 'x;
          end
          check_eq("result", 64'(bus.out_result), 64'(e.res));
          check_eq("tag", 64'(bus.out_tag), 64'(e.tag));
          obs.push_back('{res: bus.out_result, tag: bus.out_tag, cyc: cyc});
          done_cnt++;
        end
        if (bus.out_valid && !bus.out_ready) stall_cnt++;
        if (bus.in_valid && bus.in_ready)
          q.push_back('{res: ref_result(bus.in_op, bus.in_x, bus.in_y), tag: bus.in_tag});
      end
      prev_stall = bus.out_valid && !bus.out_ready && !bus.flush;
      prev_res   = bus.out_result;
      prev_tag   = bus.out_tag;
    end
  end

  // Presents one op and returns 1 ns after the edge that accepted it.
  task automatic issue(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                       input logic [TAG_W-1:0] tag);
    logic acc;
    acc          = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_x     = x;
    bus.in_y     = y;
    bus.in_tag   = tag;
    for (int n = 0; n < 50; n++) begin
      @(negedge mul_clk);
      acc = bus.in_ready;
      @(posedge mul_clk);
      #1;
      if (acc) break;
    end
    if (!acc) check_eq("issue_timeout", 64'd0, 64'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge mul_clk);
      #1;
      n++;
    end
    check_eq("drain_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic acc;
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.in_tag    = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    resetn        = 1'b0;
    #12;
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst_out_result", 64'(bus.out_result), 64'd0);
    check_eq("rst_out_tag", 64'(bus.out_tag), 64'd0);
    check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check_eq("rst_stat_done", 64'(stat_done), 64'd0);
    check_eq("rst_stat_stall", 64'(stat_stall), 64'd0);
    @(posedge mul_clk);
    #1;
    resetn = 1'b1;
    @(posedge mul_clk);
    #1;

    // 1: mul.w latency and low-word result
    obs.delete();
    bus.out_ready = 1'b1;
    issue(2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 5'd3);
    check_eq("lat_s1_valid", 64'(bus.out_valid), 64'd0);
    @(posedge mul_clk);
    #1;
    check_eq("lat_s2_valid", 64'(bus.out_valid), 64'd1);
    check_eq("t1_result", 64'(bus.out_result), 64'hFFFF_FFFE);
    check_eq("t1_tag", 64'(bus.out_tag), 64'd3);
    drain();

    // 2: high-word signed/unsigned corners
    obs.delete();
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd20);
    issue(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd21);
    issue(2'b01, 32'h8000_0000, 32'h8000_0000, 5'd22);
    drain();
    check_eq("t2_count", 64'(obs.size()), 64'd3);
    if (obs.size() == 3) begin
      check_eq("t2_mulh_m1", 64'(obs[0].res), 64'h0000_0000);
      check_eq("t2_mulhu_m1", 64'(obs[1].res), 64'hFFFF_FFFE);
      check_eq("t2_mulh_min", 64'(obs[2].res), 64'h4000_0000);
    end

    // 3: back-to-back throughput
    obs.delete();
    issue(2'b00, 32'd3, 32'd4, 5'd1);
    issue(2'b00, 32'd5, 32'd6, 5'd2);
    issue(2'b00, 32'd7, 32'd8, 5'd3);
    drain();
    check_eq("t3_count", 64'(obs.size()), 64'd3);
    if (obs.size() == 3) begin
      for (int i = 0; i < 3; i++) check_eq("t3_tag", 64'(obs[i].tag), 64'(i + 1));
      check_eq("t3_gap01", 64'(obs[1].cyc - obs[0].cyc), 64'd1);
      check_eq("t3_gap12", 64'(obs[2].cyc - obs[1].cyc), 64'd1);
    end

    // 4: backpressure fills both stages and holds the third op upstream
    obs.delete();
    bus.out_ready = 1'b0;
    fork
      begin
        issue(2'b00, 32'd10, 32'd10, 5'd4);
        issue(2'b01, 32'hFFFF_FFF0, 32'd3, 5'd5);
        issue(2'b10, 32'hFFFF_FFF0, 32'd3, 5'd6);
      end
      begin
        repeat (5) @(posedge mul_clk);
        #1;
        check_eq("t4_in_ready_full", 64'(bus.in_ready), 64'd0);
        check_eq("t4_out_valid", 64'(bus.out_valid), 64'd1);
        check_eq("t4_head_tag", 64'(bus.out_tag), 64'd4);
        bus.out_ready = 1'b1;
      end
    join
    drain();
    check_eq("t4_count", 64'(obs.size()), 64'd3);
    if (obs.size() == 3) begin
      for (int i = 0; i < 3; i++) check_eq("t4_tag", 64'(obs[i].tag), 64'(i + 4));
    end

    // 5: flush kills two in-flight ops
    obs.delete();
    issue(2'b00, 32'd11, 32'd3, 5'd8);
    issue(2'b00, 32'd5, 32'd5, 5'd9);
    bus.flush = 1'b1;
    #1;
    check_eq("t5_flush_valid", 64'(bus.out_valid), 64'd0);
    check_eq("t5_flush_ready", 64'(bus.in_ready), 64'd0);
    @(posedge mul_clk);
    #1;
    bus.flush = 1'b0;
    repeat (3) @(posedge mul_clk);
    #1;
    check_eq("t5_killed", 64'(obs.size()), 64'd0);
    issue(2'b00, 32'd7, 32'd6, 5'd10);
    drain();
    check_eq("t5_count", 64'(obs.size()), 64'd1);
    if (obs.size() == 1) begin
      check_eq("t5_result", 64'(obs[0].res), 64'd42);
      check_eq("t5_tag", 64'(obs[0].tag), 64'd10);
    end

    // Randomized traffic with backpressure and occasional flushes
    for (int c = 0; c < 2000; c++) begin
      if (!bus.in_valid && $urandom_range(0, 3) != 0) begin
        bus.in_op    = 2'($urandom_range(0, 3));
        bus.in_x     = rand_word();
        bus.in_y     = rand_word();
        bus.in_tag   = TAG_W'($urandom);
        bus.in_valid = 1'b1;
      end
      bus.out_ready = ($urandom_range(0, 9) < 7);
      bus.flush     = ($urandom_range(0, 49) == 0);
      @(negedge mul_clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge mul_clk);
      #1;
      if (acc) bus.in_valid = 1'b0;
    end
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    drain();

`ifdef MUL_PIPE_STAT_EN
    check_eq("stat_done", 64'(stat_done), 64'(done_cnt));
    check_eq("stat_stall", 64'(stat_stall), 64'(stall_cnt));
`else
    check_eq("stat_done_off", 64'(stat_done), 64'd0);
    check_eq("stat_stall_off", 64'(stat_stall), 64'd0);
`endif

    // 6: asynchronous reset while a result is waiting
    bus.out_ready = 1'b0;
    issue(2'b00, 32'd9, 32'd9, 5'd11);
    @(posedge mul_clk);
    #1;
    check_eq("t6_pre_valid", 64'(bus.out_valid), 64'd1);
    #2;
    resetn = 1'b0;
    #1;
    check_eq("t6_rst_valid", 64'(bus.out_valid), 64'd0);
    check_eq("t6_rst_result", 64'(bus.out_result), 64'd0);
    check_eq("t6_rst_tag", 64'(bus.out_tag), 64'd0);
    check_eq("t6_rst_done", 64'(stat_done), 64'd0);
    check_eq("t6_rst_stall", 64'(stat_stall), 64'd0);
    check_eq("t6_rst_in_ready", 64'(bus.in_ready), 64'd1);
    q.delete();
    done_cnt  = 0;
    stall_cnt = 0;
    @(posedge mul_clk);
    #3;
    resetn = 1'b1;
    @(posedge mul_clk);
    #1;
    check_eq("t6_post_valid", 64'(bus.out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
